// File: rtl/div_seq_if.sv
// Pipeline-side request/result bus of the divide sequencer plus its shared-ALU hookup.
// The slave modport is the sequencer; the master modport is the execute stage and ALU.
interface div_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            abort;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_rslt;
  logic [3:0]      alu_flag;

  modport master (
    output start, op, dividend, divisor, abort, alu_rslt, alu_flag,
    input  busy, done, result, alu_a, alu_b, alu_ctrl
  );

  modport slave (
    input  start, op, dividend, divisor, abort, alu_rslt, alu_flag,
    output busy, done, result, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle RV32M div/divu/rem/remu sequencer; borrows the execute-stage ALU for
// every add/sub, doing restoring division on magnitudes and a final sign fix-up pass.
module div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic      clk,
  input logic      rst_n,
  div_seq_if.slave dbus
);

  // state   | meaning
  // S_IDLE  | waiting for start, ALU driven with zeros
  // S_NEG_A | magnitude of dividend into Q
  // S_NEG_B | magnitude of divisor into D, clear R and counter
  // S_ITER  | one restoring-division step per cycle, 32 cycles
  // S_FIX   | negate quotient or remainder if needed, load result
  // S_DONE  | done pulse, back to idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [3:0]       ALU_ADD  = 4'b0000;
  localparam logic [3:0]       ALU_SUB  = 4'b0001;
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  state_t          state_q;
  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] d_q;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic            sgn_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            rem_q;
  logic            busy_q;
  logic            done_q;

  logic [XLEN-1:0] rs;
  logic [XLEN-1:0] sel;
  logic            ob;
  logic            carry;
  logic            ok;
  logic            fix_neg;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] alu_a_w;
  logic [XLEN-1:0] alu_b_w;
  logic [3:0]      alu_ctrl_w;

  logic            unused_flags;
  assign unused_flags = ^{dbus.alu_flag[3], dbus.alu_flag[1:0]};

  // The captured operands live in Q and D until their magnitudes overwrite them.
  always_comb begin
    rs      = {r_q[XLEN-2:0], q_q[XLEN-1]};
    ob      = r_q[XLEN-1];
    carry   = dbus.alu_flag[2];
    ok      = ob | carry;
    sel     = rem_q ? r_q : q_q;
    fix_neg = rem_q ? rneg_q : qneg_q;
    neg_a   = sgn_q & q_q[XLEN-1];
    neg_b   = sgn_q & d_q[XLEN-1];

    alu_a_w    = '0;
    alu_b_w    = '0;
    alu_ctrl_w = ALU_ADD;
    case (state_q)
      S_NEG_A: begin
        if (neg_a) begin
          alu_b_w    = q_q;
          alu_ctrl_w = ALU_SUB;
        end else begin
          alu_a_w = q_q;
        end
      end
      S_NEG_B: begin
        if (neg_b) begin
          alu_b_w    = d_q;
          alu_ctrl_w = ALU_SUB;
        end else begin
          alu_a_w = d_q;
        end
      end
      S_ITER: begin
        alu_a_w    = rs;
        alu_b_w    = d_q;
        alu_ctrl_w = ALU_SUB;
      end
      S_FIX: begin
        if (fix_neg) begin
          alu_b_w    = sel;
          alu_ctrl_w = ALU_SUB;
        end else begin
          alu_a_w = sel;
        end
      end
      default: begin
        alu_a_w    = '0;
        alu_b_w    = '0;
        alu_ctrl_w = ALU_ADD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rem_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (dbus.abort && (state_q != S_IDLE)) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          // An abort in the same cycle as start suppresses acceptance.
          if (dbus.start && !dbus.abort) begin
            q_q     <= dbus.dividend;
            d_q     <= dbus.divisor;
            sgn_q   <= ~dbus.op[0];
            rem_q   <= dbus.op[1];
            qneg_q  <= ~dbus.op[0] & (dbus.dividend[XLEN-1] ^ dbus.divisor[XLEN-1])
                       & (|dbus.divisor);
            rneg_q  <= ~dbus.op[0] & dbus.dividend[XLEN-1];
            busy_q  <= 1'b1;
            state_q <= S_NEG_A;
          end
        end
        S_NEG_A: begin
          q_q     <= dbus.alu_rslt;
          state_q <= S_NEG_B;
        end
        S_NEG_B: begin
          d_q     <= dbus.alu_rslt;
          r_q     <= '0;
          cnt_q   <= '0;
          state_q <= S_ITER;
        end
        S_ITER: begin
          r_q   <= ok ? dbus.alu_rslt : rs;
          q_q   <= {q_q[XLEN-2:0], ok};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= dbus.alu_rslt;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dbus.busy     = busy_q;
  assign dbus.done     = done_q;
  assign dbus.result   = result_q;
  assign dbus.alu_a    = alu_a_w;
  assign dbus.alu_b    = alu_b_w;
  assign dbus.alu_ctrl = alu_ctrl_w;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: vector table plus control-path sequences, with an ALU model in the loop.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_if #(.XLEN(32)) dbus ();

  div_seq #(.XLEN(32), .CNT_W(5)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dbus (dbus)
  );

  // Shared ALU: add/sub with {Ovf, Carry, Neg, Zero}; sub carry = no borrow.
  logic [32:0] alu_sum;
  logic        alu_ovf;
  always_comb begin
    if (dbus.alu_ctrl == 4'b0001) begin
      alu_sum = {1'b0, dbus.alu_a} + {1'b0, ~dbus.alu_b} + 33'd1;
      alu_ovf = (dbus.alu_a[31] != dbus.alu_b[31]) && (alu_sum[31] != dbus.alu_a[31]);
    end else begin
      alu_sum = {1'b0, dbus.alu_a} + {1'b0, dbus.alu_b};
      alu_ovf = (dbus.alu_a[31] == dbus.alu_b[31]) && (alu_sum[31] != dbus.alu_a[31]);
    end
    dbus.alu_rslt = alu_sum[31:0];
    dbus.alu_flag = {alu_ovf, alu_sum[32], alu_sum[31], (alu_sum[31:0] == 32'd0)};
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] absb;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] abs_div(input logic [1:0] op, input logic [31:0] b);
    return (!op[0] && b[31]) ? (~b + 32'd1) : b;
  endfunction

  // One operation from start to done (or abort), checking timing, ITER drive and result.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int restart_cyc,
                        input int abort_cyc, input bit start_in_done);
    sb_t         e;
    logic [31:0] absb;
    logic [3:0]  bad_ctrl;
    logic [31:0] bad_b;
    bit          iter_ok;
    bit          seen_done;
    bit          done_after_abort;
    iter_ok          = 1'b1;
    seen_done        = 1'b0;
    done_after_abort = 1'b0;
    bad_ctrl         = 4'b0001;
    bad_b            = 32'd0;
    absb             = abs_div(op, b);
    @(negedge clk);
    dbus.start    = 1'b1;
    dbus.op       = op;
    dbus.dividend = a;
    dbus.divisor  = b;
    if (abort_cyc == 0) sb_q.push_back('{exp, absb});
    for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        dbus.start = 1'b0;
        check({name, " busy_c1"}, {31'd0, dbus.busy}, 32'd1);
      end
      if (restart_cyc != 0 && cyc == restart_cyc) begin
        dbus.start    = 1'b1;
        dbus.op       = 2'b11;
        dbus.dividend = 32'd9;
        dbus.divisor  = 32'd3;
      end
      if (restart_cyc != 0 && cyc == restart_cyc + 1) dbus.start = 1'b0;
      if (cyc >= 3 && cyc <= 34 && (abort_cyc == 0 || cyc <= abort_cyc)) begin
        if (iter_ok && (dbus.alu_ctrl !== 4'b0001 || dbus.alu_b !== absb)) begin
          iter_ok  = 1'b0;
          bad_ctrl = dbus.alu_ctrl;
          bad_b    = dbus.alu_b;
        end
      end
      if (abort_cyc == 0 && cyc == 35)
        check({name, " busy_fix"}, {31'd0, dbus.busy}, 32'd1);
      if (abort_cyc != 0 && cyc == abort_cyc) dbus.abort = 1'b1;
      if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
        dbus.abort = 1'b0;
        check({name, " busy_after_abort"}, {31'd0, dbus.busy}, 32'd0);
        check({name, " result_held"}, dbus.result, last_res);
      end
      if (dbus.done === 1'b1) begin
        if (abort_cyc != 0) begin
          done_after_abort = 1'b1;
        end else begin
          seen_done = 1'b1;
          check({name, " latency"}, cyc, 32'd36);
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: done with empty scoreboard, actual=0x%08h", name, dbus.result);
          end else begin
            e = sb_q.pop_front();
            check({name, " result"}, dbus.result, e.res);
            last_res = e.res;
          end
          check({name, " busy_done"}, {31'd0, dbus.busy}, 32'd0);
          if (start_in_done) begin
            dbus.start    = 1'b1;
            dbus.op       = 2'b01;
            dbus.dividend = 32'd1;
            dbus.divisor  = 32'd1;
            @(negedge clk);
            dbus.start = 1'b0;
            check({name, " start_in_done_ignored"}, {31'd0, dbus.busy}, 32'd0);
            check({name, " result_after_done"}, dbus.result, last_res);
          end
        end
      end
    end
    if (abort_cyc == 0 && !seen_done) begin
      checks++;
      failures++;
      $display("FAIL %s: no done within 40 cycles, actual=0 required=1", name);
      sb_q.delete();
    end
    if (abort_cyc != 0) check({name, " no_done"}, {31'd0, done_after_abort}, 32'd0);
    checks++;
    if (!iter_ok) begin
      failures++;
      $display("FAIL %s iter_drive: actual ctrl=%b b=0x%08h required ctrl=0001 b=0x%08h",
               name, bad_ctrl, bad_b, absb);
    end
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dbus.start    = 1'b0;
    dbus.op       = 2'b00;
    dbus.dividend = 32'd0;
    dbus.divisor  = 32'd0;
    dbus.abort    = 1'b0;

    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14});
    vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2});
    vecs.push_back('{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD});
    vecs.push_back('{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF});
    vecs.push_back('{2'b00, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF});
    vecs.push_back('{2'b10, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFF0});
    vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF});
    vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5});
    vecs.push_back('{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000});
    vecs.push_back('{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0});
    vecs.push_back('{2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF});
    vecs.push_back('{2'b01, 32'hFFFFFFFF,   32'h80000001,   32'd1});
    vecs.push_back('{2'b11, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE});
    vecs.push_back('{2'b00, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2});
    vecs.push_back('{2'b10, 32'd100,        32'hFFFFFFF9,   32'd2});
    vecs.push_back('{2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14});
    vecs.push_back('{2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE});
    vecs.push_back('{2'b01, 32'd7,          32'd100,        32'd0});
    vecs.push_back('{2'b11, 32'hDEADBEEF,   32'h10,         32'hF});

    repeat (2) @(negedge clk);
    check("reset busy",     {31'd0, dbus.busy}, 32'd0);
    check("reset done",     {31'd0, dbus.done}, 32'd0);
    check("reset result",   dbus.result, 32'd0);
    check("reset alu_a",    dbus.alu_a, 32'd0);
    check("reset alu_b",    dbus.alu_b, 32'd0);
    check("reset alu_ctrl", {28'd0, dbus.alu_ctrl}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rop;
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      rop = (k % 2 == 0) ? 2'b01 : 2'b11;
      run_op($sformatf("rand%0d", k), rop, ra, rb, rop[1] ? (ra % rb) : (ra / rb), 0, 0, 1'b0);
    end

    run_op("restart", 2'b01, 32'd100, 32'd7, 32'd14, 10, 0, 1'b1);
    run_op("abort", 2'b00, 32'hFFFFFFF9, 32'd2, 32'h0, 0, 20, 1'b0);
    run_op("post_abort", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, 0, 1'b0);

    @(negedge clk);
    dbus.start    = 1'b1;
    dbus.abort    = 1'b1;
    dbus.op       = 2'b01;
    dbus.dividend = 32'd50;
    dbus.divisor  = 32'd5;
    @(negedge clk);
    dbus.start = 1'b0;
    dbus.abort = 1'b0;
    check("idle_abort busy", {31'd0, dbus.busy}, 32'd0);
    @(negedge clk);
    check("idle_abort busy2", {31'd0, dbus.busy}, 32'd0);

    @(negedge clk);
    dbus.start    = 1'b1;
    dbus.op       = 2'b01;
    dbus.dividend = 32'hFFFFFFFF;
    dbus.divisor  = 32'd3;
    @(negedge clk);
    dbus.start = 1'b0;
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst busy",     {31'd0, dbus.busy}, 32'd0);
    check("async_rst done",     {31'd0, dbus.done}, 32'd0);
    check("async_rst result",   dbus.result, 32'd0);
    check("async_rst alu_a",    dbus.alu_a, 32'd0);
    check("async_rst alu_b",    dbus.alu_b, 32'd0);
    check("async_rst alu_ctrl", {28'd0, dbus.alu_ctrl}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_res = 32'd0;
    begin
      bit stray_done;
      stray_done = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (dbus.done === 1'b1) stray_done = 1'b1;
      end
      check("async_rst no_done", {31'd0, stray_done}, 32'd0);
    end
    run_op("after_rst", 2'b01, 32'd9, 32'd3, 32'd3, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle RV32M divide/remainder sequencer (div, divu, rem, remu).
- Owns no adder of its own. It drives the shared 32-bit ALU's operand and ALUControl inputs every cycle and samples the combinational result and flags the same cycle.
- Sits beside the execute stage. The pipeline stalls on busy and takes the result on the done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 div, 01 divu, 10 rem, 11 remu.
- dividend  input  32  rs1 value; captured on start.
- divisor  input  32  rs2 value; captured on start.
- abort  input  1  pipeline flush; cancels the operation in flight.
- busy  output  1  high from the cycle after start acceptance through the FIX state.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  32  quotient or remainder; held until the next accepted start.
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- alu_ctrl  output  4  ALUControl: 0000 add, 0001 sub.
- alu_rslt  input  32  ALU result (combinational, same cycle).
- alu_flag  input  4  {Ovf, Carry, Neg, Zero}; only Carry is used (sub: 1 means a >= b unsigned).

Behaviour:
Reset (asynchronous, any state):
- State IDLE.
- busy=0, done=0, result=0.
- alu_a=0, alu_b=0, alu_ctrl=0000.
- Internal registers cleared.
- Reset mid-operation discards the operation with no done.

Operand and control drive:
- alu_a, alu_b and alu_ctrl are a registered-state decode: a pure function of state plus internal registers.
- IDLE and DONE drive 0/0/0000.

FSM (one state per cycle unless noted):
- IDLE: on start, capture operands and op; sgn = ~op[0]; set qneg and rneg; go to NEG_A.
  - qneg = sgn & (dividend[31] ^ divisor[31]) & (divisor != 0).
  - rneg = sgn & dividend[31].
- NEG_A: abs of dividend.
  - If sgn & dividend[31]: alu_a=0, alu_b=dividend, alu_ctrl=0001.
  - Else: alu_a=dividend, alu_b=0, alu_ctrl=0000.
  - Q <= alu_rslt.
- NEG_B: same rule applied to divisor; D <= alu_rslt; R <= 0; cnt <= 0.
- ITER: 32 cycles, restoring division.
  - Rs = {R[30:0], Q[31]}; ob = R[31] (shifted-out bit).
  - Drive alu_a=Rs, alu_b=D, alu_ctrl=0001.
  - ok = ob | Carry.
  - R <= ok ? alu_rslt : Rs.
  - Q <= {Q[30:0], ok}.
  - cnt increments; leave after cnt=31.
- FIX: select sel = op[1] ? R : Q, and neg = op[1] ? rneg : qneg.
  - If neg: alu_a=0, alu_b=sel, alu_ctrl=0001.
  - Else: alu_a=sel, alu_b=0, alu_ctrl=0000.
  - result <= alu_rslt. Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - A start in this cycle is ignored.

Latency and handshake:
- Fixed latency: start accepted at edge 0, done high in cycle 36 (2 + 32 + 1 + 1).
- There is no data-dependent early exit.
- start while busy or in DONE is ignored; operands are not re-captured.

Boundary cases (fall out of the algorithm, no special paths):
- Divide by zero: quotient 0xFFFFFFFF and remainder = dividend, for signed and unsigned. This holds because qneg is forced 0 when the divisor is zero.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. The ALU negation wraps.

Abort:
- Any non-IDLE state returns to IDLE at the next edge.
- No done; busy drops the same edge; result keeps its previous value.
- abort in IDLE has no effect, and start is also ignored in that cycle.

Test Plan:
- divu 100/7 -> done exactly 36 cycles after start; result 14. Repeat as remu -> 2.
- div 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD. rem same operands -> 0xFFFFFFFF.
- Divide by zero: div 0xFFFFFFF0/0 -> 0xFFFFFFFF; rem -> 0xFFFFFFF0; divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5.
- Overflow: div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0. divu 0xFFFFFFFF/1 -> 0xFFFFFFFF (checks the ob path).
- Control:
  - start pulsed again at cycle 10 with new operands -> ignored; first result delivered at cycle 36.
  - abort at cycle 20 -> busy=0 next cycle, no done, result unchanged.
  - A new start then completes normally.
- Async reset asserted mid-ITER (between edges) -> busy, done, result, alu_* go 0 immediately. After release, a fresh divu 9/3 -> 3.
- Every ITER cycle: scoreboard checks alu_ctrl=0001 and alu_b=|divisor|, with a reference ALU model in the loop.
